uc_bcast_scheduler: RTL

- Sequences delivery of each accepted unit clause (UC) from the unit clause arbiter into every engine's input queue (UCQ_OUT).
- Tracks per-engine pending delivery under back-pressure and sequences conflict handling.
- Detects global quiescence: no UC in flight and all engines idle, i.e. the BCP round is finished.
- Sits between the UC arbiter output and the NUM_ENGINE engines; flushed by the top-level controller on backtrack.

---
 rtl/uc_bcast_scheduler_pkg.sv | 17 +
 rtl/uc_bcast_scheduler_if.sv | 26 ++
 rtl/uc_bcast_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uc_bcast_scheduler_pkg.sv
// Shared types for the unit-clause broadcast scheduler: literal type,
// null literal and the scheduler state encoding.
package uc_pkg;

    localparam int LIT_W = 8;

    typedef logic signed [LIT_W-1:0] lit_t;

    localparam lit_t LIT_NULL = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        CONFL = 2'd2
    } bcast_state_e;

endpackage

// File: rtl/uc_bcast_scheduler_if.sv
// Arbiter-side and engine-side signals of the broadcast scheduler.
// master: the environment (arbiter + engines); slave: the scheduler.
interface uc_bcast_scheduler_if #(
    parameter int NUM_ENGINE = 4
) ();

    logic                  uca_valid;
    uc_pkg::lit_t          uca_lit;
    logic                  uca_ready;
    logic                  uca_conflict;
    logic [NUM_ENGINE-1:0] eng_full;
    logic [NUM_ENGINE-1:0] eng_busy;
    logic [NUM_ENGINE-1:0] eng_push;
    uc_pkg::lit_t          eng_lit;

    modport master (
        output uca_valid, uca_lit, uca_conflict, eng_full, eng_busy,
        input  uca_ready, eng_push, eng_lit
    );

    modport slave (
        input  uca_valid, uca_lit, uca_conflict, eng_full, eng_busy,
        output uca_ready, eng_push, eng_lit
    );

endinterface

// File: rtl/uc_bcast_scheduler.sv
// Broadcasts each accepted unit clause to every engine queue, tracking
// per-engine pending delivery under back-pressure, handles conflicts and
// flags quiescence of the BCP round.
//
// state | meaning
// IDLE  | nothing in flight, ready for a new unit clause
// BCAST | literal in eng_lit still owed to engines flagged in pending
// CONFL | conflict seen; everything frozen until flush
module uc_bcast_scheduler
    import uc_pkg::*;
#(
    parameter int NUM_ENGINE = 4,
    parameter int QUIET_CYC  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uc_bcast_scheduler_if.slave  bus,
    input  logic                 flush,
    output logic                 conflict,
    output logic                 quiesce,
    output logic [CNT_W-1:0]     bcast_cnt
);

    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYC);

    bcast_state_e          state_q, state_d;
    logic [NUM_ENGINE-1:0] pending_q, pending_d;
    lit_t                  lit_q, lit_d;
    logic                  conflict_d;
    logic                  cnt_inc;
    logic [QW-1:0]         quiet_q, quiet_d;
    logic                  quiet_ok;

    logic                  hold;
    logic                  ready_base;
    logic                  xfer;
    logic                  load;
    logic [NUM_ENGINE-1:0] remaining;

    // Handshake and push strobes; flush and a fresh conflict freeze both.
    always_comb begin
        hold       = flush | (bus.uca_conflict & (state_q != CONFL));
        ready_base = (state_q == IDLE) |
                     ((state_q == BCAST) & ((pending_q & bus.eng_full) == '0));
        bus.uca_ready = ready_base & ~hold & ~rst;
        bus.eng_push  = ((state_q == BCAST) & ~hold) ? (pending_q & ~bus.eng_full) : '0;
        xfer          = bus.uca_valid & bus.uca_ready;
        load          = xfer & (bus.uca_lit != LIT_NULL);
        remaining     = pending_q & ~bus.eng_push;
    end

    // Next-state logic; flush overrides conflict, conflict overrides delivery.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        lit_d      = lit_q;
        conflict_d = conflict;
        cnt_inc    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    lit_d     = bus.uca_lit;
                    pending_d = '1;
                    state_d   = BCAST;
                end
            end
            BCAST: begin
                pending_d = remaining;
                if (remaining == '0) begin
                    cnt_inc = 1'b1;
                    if (load) begin
                        lit_d     = bus.uca_lit;
                        pending_d = '1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CONFL: begin
            end
            default: state_d = IDLE;
        endcase

        if (bus.uca_conflict && state_q != CONFL) begin
            state_d    = CONFL;
            pending_d  = '0;
            lit_d      = lit_q;
            conflict_d = 1'b1;
            cnt_inc    = 1'b0;
        end

        if (flush) begin
            state_d    = IDLE;
            pending_d  = '0;
            lit_d      = lit_q;
            conflict_d = 1'b0;
            cnt_inc    = 1'b0;
        end
    end

    // Idle-cycle run length used for quiescence detection.
    always_comb begin
        quiet_ok = (state_q == IDLE) & ~bus.uca_valid & (bus.eng_busy == '0) & ~conflict;
        if (!quiet_ok)
            quiet_d = '0;
        else if (quiet_q == QUIET_MAX)
            quiet_d = quiet_q;
        else
            quiet_d = quiet_q + 1'b1;
    end

    // Control state, pending mask, literal and conflict flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            lit_q     <= LIT_NULL;
            conflict  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lit_q     <= lit_d;
            conflict  <= conflict_d;
        end
    end

    // Saturating broadcast counter and quiescence flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_cnt <= '0;
            quiet_q   <= '0;
            quiesce   <= 1'b0;
        end else if (flush) begin
            bcast_cnt <= '0;
            quiet_q   <= '0;
            quiesce   <= 1'b0;
        end else begin
            if (cnt_inc && bcast_cnt != '1)
                bcast_cnt <= bcast_cnt + 1'b1;
            quiet_q <= quiet_d;
            quiesce <= (quiet_d == QUIET_MAX);
        end
    end

    assign bus.eng_lit = lit_q;

endmodule
